// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl: scans ROM words 0..NUM_WORDS-1 through a zero-wait ROM. It
// accumulates a 36-bit unsigned sum and tracks the largest word and its
// address.
// Optional feature: define ROM_SCAN_MAX_EN to build the max_val/max_addr
// tracker. Without it, both outputs are tied to 0.
module rom_scan_ctrl #(
  parameter int NUM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  rom_addr,
  output logic        rom_rd_en,
  input  logic [31:0] rom_data,
  output logic        busy,
  output logic        done,
  output logic [35:0] sum,
  output logic [31:0] max_val,
  output logic [3:0]  max_addr
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FIN = 2'd2} state_e;

  localparam logic [3:0] LAST_ADDR = 4'(NUM_WORDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  rom_addr_q, rom_addr_d;
  logic [35:0] sum_q, sum_d;

  // State, address and sum registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_addr_q <= 4'd0;
      sum_q      <= 36'd0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      sum_q      <= sum_d;
    end
  end

  // Next state, address walk and accumulation; start only matters in IDLE
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    sum_d      = sum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sum_d      = 36'd0;
          rom_addr_d = 4'd0;
          state_d    = READ;
        end
      end
      READ: begin
        sum_d = sum_q + {4'd0, rom_data};
        if (rom_addr_q == LAST_ADDR) begin
          rom_addr_d = 4'd0;
          state_d    = FIN;
        end else begin
          rom_addr_d = rom_addr_q + 4'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: begin
        state_d    = IDLE;
        rom_addr_d = 4'd0;
      end
    endcase
  end

  assign rom_addr  = rom_addr_q;
  assign rom_rd_en = (state_q == READ);
  assign busy      = (state_q == READ);
  assign done      = (state_q == FIN);
  assign sum       = sum_q;

`ifdef ROM_SCAN_MAX_EN
  logic [31:0] max_val_q, max_val_d;
  logic [3:0]  max_addr_q, max_addr_d;

  // Max tracker registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_val_q  <= 32'd0;
      max_addr_q <= 4'd0;
    end else begin
      max_val_q  <= max_val_d;
      max_addr_q <= max_addr_d;
    end
  end

  // Address 0 seeds the tracker. Later words replace it only when strictly
  // greater, so ties keep the lowest address.
  always_comb begin
    max_val_d  = max_val_q;
    max_addr_d = max_addr_q;
    if (state_q == IDLE && start) begin
      max_val_d  = 32'd0;
      max_addr_d = 4'd0;
    end else if (state_q == READ) begin
      if (rom_addr_q == 4'd0 || rom_data > max_val_q) begin
        max_val_d  = rom_data;
        max_addr_d = rom_addr_q;
      end
    end
  end

  assign max_val  = max_val_q;
  assign max_addr = max_addr_q;
`else
  assign max_val  = 32'd0;
  assign max_addr = 4'd0;
`endif

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Directed bench for rom_scan_ctrl. One 16-word instance and one 4-word
// instance each read their own behavioural ROM.
module tb_rom_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [3:0]  addr_a, addr_b, maddr_a, maddr_b;
  logic        rd_a, rd_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] data_a, data_b, max_a, max_b;
  logic [35:0] sum_a, sum_b;

  logic [31:0] rom_a [16];
  logic [31:0] rom_b [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign data_a = rd_a ? rom_a[addr_a] : 32'd0;
  assign data_b = rd_b ? rom_b[addr_b[1:0]] : 32'd0;

  rom_scan_ctrl #(.NUM_WORDS(16)) dut (
    .clk(clk), .rst(rst), .start(start_a), .rom_addr(addr_a), .rom_rd_en(rd_a),
    .rom_data(data_a), .busy(busy_a), .done(done_a), .sum(sum_a),
    .max_val(max_a), .max_addr(maddr_a)
  );

  rom_scan_ctrl #(.NUM_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_b), .rom_addr(addr_b), .rom_rd_en(rd_b),
    .rom_data(data_b), .busy(busy_b), .done(done_b), .sum(sum_b),
    .max_val(max_b), .max_addr(maddr_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".addr"}, 64'(addr_a), 64'd0);
    chk({tag, ".rd"},   64'(rd_a),   64'd0);
    chk({tag, ".busy"}, 64'(busy_a), 64'd0);
    chk({tag, ".done"}, 64'(done_a), 64'd0);
  endtask

  // Full 16-word scan on the big instance. When hold is set, start stays high
  // for the whole scan and is left high on return.
  task automatic run_scan(input bit hold, input logic [35:0] exp_sum,
                          input logic [31:0] exp_max, input logic [3:0] exp_maddr);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); if (!hold) start_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("read.busy", 64'(busy_a), 64'd1);
      chk("read.rd",   64'(rd_a),   64'd1);
      chk("read.done", 64'(done_a), 64'd0);
      chk("read.addr", 64'(addr_a), 64'(i));
      @(negedge clk);
    end
    chk("fin.done", 64'(done_a), 64'd1);
    chk("fin.busy", 64'(busy_a), 64'd0);
    chk("fin.rd",   64'(rd_a),   64'd0);
    chk("fin.addr", 64'(addr_a), 64'd0);
    chk("sum",      64'(sum_a),  64'(exp_sum));
    chk("max_val",  64'(max_a),  64'(exp_max));
    chk("max_addr", 64'(maddr_a), 64'(exp_maddr));
    @(negedge clk);
    chk_idle_a("post");
  endtask

  logic [31:0] ex_max;
  logic [3:0]  ex_maddr;
  int          n_done;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 16; i++) rom_a[i] = 32'(i + 1);
    rom_b[0] = 32'h5; rom_b[1] = 32'h9; rom_b[2] = 32'h9; rom_b[3] = 32'h2;

    // Reset state
    repeat (2) @(negedge clk);
    chk_idle_a("rst");
    chk("rst.sum", 64'(sum_a), 64'd0);
    chk("rst.max", 64'(max_a), 64'd0);
    chk("rst.maddr", 64'(maddr_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_a("idle");

    // Incrementing words 1..16
`ifdef ROM_SCAN_MAX_EN
    ex_max = 32'h10; ex_maddr = 4'hF;
`else
    ex_max = 32'h0;  ex_maddr = 4'h0;
`endif
    run_scan(1'b0, 36'h88, ex_max, ex_maddr);
    repeat (3) @(negedge clk);
    chk("hold.sum", 64'(sum_a), 64'h88);
    chk("hold.max", 64'(max_a), 64'(ex_max));

    // All-ones words: no overflow, and the tie keeps address 0
    for (int i = 0; i < 16; i++) rom_a[i] = 32'hFFFF_FFFF;
`ifdef ROM_SCAN_MAX_EN
    ex_max = 32'hFFFF_FFFF; ex_maddr = 4'h0;
`endif
    run_scan(1'b0, 36'hF_FFFF_FFF0, ex_max, ex_maddr);

    // Start held high: it is not queued from FIN, and it re-arms only in IDLE
    for (int i = 0; i < 16; i++) rom_a[i] = 32'(i + 1);
`ifdef ROM_SCAN_MAX_EN
    ex_max = 32'h10; ex_maddr = 4'hF;
`endif
    run_scan(1'b1, 36'h88, ex_max, ex_maddr);
    @(negedge clk);
    chk("restart.busy", 64'(busy_a), 64'd1);
    chk("restart.addr", 64'(addr_a), 64'd0);
    start_a = 1'b0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_a) n_done++;
      @(negedge clk);
    end
    chk("restart.ndone", 64'(n_done), 64'd1);
    chk("restart.sum", 64'(sum_a), 64'h88);

    // Reset pulsed at address 7 takes effect without a clock edge
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int c = 0; c < 7; c++) @(negedge clk);
    chk("abort.addr7", 64'(addr_a), 64'd7);
    rst = 1'b1;
    #1;
    chk_idle_a("abort");
    chk("abort.sum", 64'(sum_a), 64'd0);
    chk("abort.max", 64'(max_a), 64'd0);
    chk("abort.maddr", 64'(maddr_a), 64'd0);
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_a) n_done++;
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_a) n_done++;
    end
    chk("abort.ndone", 64'(n_done), 64'd0);
    run_scan(1'b0, 36'h88, ex_max, ex_maddr);

    // 4-word instance: words 5,9,9,2
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b.busy", 64'(busy_b), 64'd1);
      chk("b.addr", 64'(addr_b), 64'(i));
      @(negedge clk);
    end
    chk("b.done", 64'(done_b), 64'd1);
    chk("b.rd",   64'(rd_b),   64'd0);
    chk("b.sum",  64'(sum_b),  64'h19);
`ifdef ROM_SCAN_MAX_EN
    chk("b.max",   64'(max_b),   64'h9);
    chk("b.maddr", 64'(maddr_b), 64'h1);
`else
    chk("b.max",   64'(max_b),   64'h0);
    chk("b.maddr", 64'(maddr_b), 64'h0);
`endif
    @(negedge clk);
    chk("b.done_off", 64'(done_b), 64'd0);
    chk("b.busy_off", 64'(busy_b), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
